clk_div_prog: RTL and testbench



---
 rtl/clk_div_prog.sv | 125 ++++++++++++
 tb/tb_clk_div_prog.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Programmable clock divider with glitch-free divisor reload and
// run/halt/single-step control for CPU debug stepping.
`timescale 1ns/1ps
module clk_div_prog #(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 12
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic [WIDTH-1:0] div_in,
   input  logic             div_load,
   input  logic             run,
   input  logic             step,
   output logic             clk_out,
   output logic             clk_en,
   output logic             halted,
   output logic [WIDTH-1:0] div_cur
);

   typedef enum logic [1:0] {
      HALT,
      RUN,
      STEP
   } state_e;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
   localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

   function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
      clamp = (v[WIDTH-1:1] == '0) ? TWO : v;
   endfunction

   localparam logic [WIDTH-1:0] DEF_DIV = clamp(WIDTH'(DEFAULT_DIV));

   state_e           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] div_cur_q, div_cur_d;
   logic [WIDTH-1:0] div_pend_q, div_pend_d;
   logic             clk_out_q, clk_out_d;
   logic             clk_en_q, clk_en_d;

   logic [WIDTH-1:0] term_cnt;
   logic             at_term;
   logic [WIDTH:0]   hi;
   logic [WIDTH:0]   cnt_inc;
   logic             do_wrap;
   logic             do_count;

   assign term_cnt = div_cur_q - ONE;
   assign at_term  = (cnt_q == term_cnt);
   // Odd divisors round the high phase up, so it is one cycle longer.
   assign hi       = ({1'b0, div_cur_q} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
   assign cnt_inc  = {1'b0, cnt_q} + {{WIDTH{1'b0}}, 1'b1};

   always_comb begin
      state_d  = state_q;
      do_wrap  = 1'b0;
      do_count = 1'b0;
      unique case (state_q)
         HALT: begin
            if (run) begin
               do_wrap = 1'b1;
               state_d = RUN;
            end else if (step) begin
               do_wrap = 1'b1;
               state_d = STEP;
            end
         end
         RUN, STEP: begin
            if (!at_term) begin
               do_count = 1'b1;
            end else if (run) begin
               do_wrap = 1'b1;
               state_d = RUN;
            end else begin
               state_d = HALT;
            end
         end
         default: state_d = HALT;
      endcase
   end

   always_comb begin
      cnt_d     = cnt_q;
      div_cur_d = div_cur_q;
      clk_out_d = 1'b0;
      clk_en_d  = 1'b0;
      // The divisor only switches at a wrap, so a period is never cut short.
      if (do_wrap) begin
         cnt_d     = '0;
         div_cur_d = div_pend_q;
         clk_out_d = 1'b1;
         clk_en_d  = 1'b1;
      end else if (do_count) begin
         cnt_d     = cnt_inc[WIDTH-1:0];
         clk_out_d = (cnt_inc < hi);
      end
   end

   assign div_pend_d = div_load ? clamp(div_in) : div_pend_q;

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state_q    <= HALT;
         cnt_q      <= DEF_DIV - ONE;
         div_cur_q  <= DEF_DIV;
         div_pend_q <= DEF_DIV;
         clk_out_q  <= 1'b0;
         clk_en_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         div_cur_q  <= div_cur_d;
         div_pend_q <= div_pend_d;
         clk_out_q  <= clk_out_d;
         clk_en_q   <= clk_en_d;
      end
   end

   assign clk_out = clk_out_q;
   assign clk_en  = clk_en_q;
   assign halted  = (state_q == HALT);
   assign div_cur = div_cur_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: per-cycle expected outputs are
// queued with the stimulus and popped one per clock edge.
`timescale 1ns/1ps
module tb_clk_div_prog;

   logic       clk_in = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] div_in = 8'd0;
   logic       div_load = 1'b0;
   logic       run = 1'b0;
   logic       step = 1'b0;
   logic       clk_out;
   logic       clk_en;
   logic       halted;
   logic [7:0] div_cur;

   typedef struct packed {
      logic       co;
      logic       ce;
      logic       h;
      logic [7:0] dc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   clk_div_prog #(
      .WIDTH(8),
      .DEFAULT_DIV(12)
   ) dut (
      .clk_in(clk_in),
      .reset(reset),
      .div_in(div_in),
      .div_load(div_load),
      .run(run),
      .step(step),
      .clk_out(clk_out),
      .clk_en(clk_en),
      .halted(halted),
      .div_cur(div_cur)
   );

   always #41.5 clk_in = ~clk_in;

   task automatic push_period(input int n, input logic h);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.co = (i < (n + 1) / 2);
         e.ce = (i == 0);
         e.h  = h;
         e.dc = 8'(n);
         sb.push_back(e);
      end
   endtask

   task automatic push_halt(input int k, input int n);
      exp_t e;
      for (int i = 0; i < k; i++) begin
         e.co = 1'b0;
         e.ce = 1'b0;
         e.h  = 1'b1;
         e.dc = 8'(n);
         sb.push_back(e);
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int k);
      exp_t e;
      exp_t o;
      for (int i = 0; i < k; i++) begin
         @(posedge clk_in);
         #1;
         cyc++;
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL sb_underflow cycle=%0d observed=empty expected=entry",
                   cyc);
         end else begin
            e = sb.pop_front();
            o.co = clk_out;
            o.ce = clk_en;
            o.h  = halted;
            o.dc = div_cur;
            checks++;
            assert (o === e) else begin
               failures++;
               $error("FAIL cyc%0d out/en/halt/div observed=%0b/%0b/%0b/%0d expected=%0b/%0b/%0b/%0d",
                      cyc, o.co, o.ce, o.h, o.dc, e.co, e.ce, e.h, e.dc);
            end
         end
      end
   endtask

   task automatic drain();
      while (sb.size() > 0) cycles(1);
   endtask

   task automatic reset_now(input string tag);
      reset = 1'b0;
      #1;
      chk({tag, "_clk_out"}, 8'(clk_out), 8'd0);
      chk({tag, "_clk_en"}, 8'(clk_en), 8'd0);
      chk({tag, "_halted"}, 8'(halted), 8'd1);
      chk({tag, "_div_cur"}, div_cur, 8'd12);
      sb.delete();
      #5;
      reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      run = 1'b1;
      #0.1 reset = 1'b0;
      #0.4;
      chk("rst_clk_out", 8'(clk_out), 8'd0);
      chk("rst_clk_en", 8'(clk_en), 8'd0);
      chk("rst_halted", 8'(halted), 8'd1);
      chk("rst_div_cur", div_cur, 8'd12);
      #0.5 reset = 1'b1;

      // free run at the default divisor
      push_period(12, 1'b0);
      push_period(12, 1'b0);
      drain();

      // odd divisor loaded mid-period
      push_period(12, 1'b0);
      cycles(3);
      div_load = 1'b1;
      div_in   = 8'd5;
      cycles(1);
      div_load = 1'b0;
      cycles(8);
      push_period(5, 1'b0);
      push_period(5, 1'b0);
      push_period(5, 1'b0);
      drain();

      // load on the wrap edge, then overridden mid-period
      div_load = 1'b1;
      div_in   = 8'd4;
      push_period(5, 1'b0);
      push_period(6, 1'b0);
      push_period(6, 1'b0);
      cycles(1);
      div_load = 1'b0;
      cycles(1);
      div_load = 1'b1;
      div_in   = 8'd6;
      cycles(1);
      div_load = 1'b0;
      drain();

      // clamp of 0 and 1
      push_period(6, 1'b0);
      cycles(1);
      div_load = 1'b1;
      div_in   = 8'd0;
      cycles(1);
      div_in   = 8'd1;
      cycles(1);
      div_load = 1'b0;
      for (int i = 0; i < 4; i++) push_period(2, 1'b0);
      drain();

      // back to 12, then halt at cnt=2
      div_load = 1'b1;
      div_in   = 8'd12;
      push_period(2, 1'b0);
      cycles(1);
      div_load = 1'b0;
      push_period(12, 1'b0);
      cycles(1);
      cycles(3);
      run = 1'b0;
      push_halt(3, 12);
      drain();

      // single step, with a step pulse inside STEP ignored
      step = 1'b1;
      push_period(12, 1'b0);
      cycles(1);
      step = 1'b0;
      cycles(3);
      step = 1'b1;
      cycles(1);
      step = 1'b0;
      push_halt(2, 12);
      drain();

      // run raised during STEP continues without a gap
      step = 1'b1;
      push_period(12, 1'b0);
      cycles(1);
      step = 1'b0;
      cycles(5);
      run = 1'b1;
      push_period(12, 1'b0);
      push_period(12, 1'b0);
      drain();

      // async reset right after a rising edge
      push_period(12, 1'b0);
      cycles(1);
      reset_now("rst_cnt0");
      push_period(12, 1'b0);
      cycles(8);

      // pending divisor must also return to default
      div_load = 1'b1;
      div_in   = 8'd3;
      cycles(1);
      div_load = 1'b0;
      reset_now("rst_cnt8");
      push_period(12, 1'b0);
      push_period(12, 1'b0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
